fpmul_result_buffer: RTL

- Output stage directly downstream of the single-precision floating-point multiplier.
- Captures each product word with its underflow/overflow flags into a small FIFO, and drives a valid/ready handshake toward the consumer.
- Keeps sticky exception flags and a saturating count of accepted results for software/status readout.

---
 rtl/fpmul_result_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fpmul_result_buffer.sv
// fpmul_result_buffer: registered output FIFO behind the FP32 multiplier, with sticky exception flags and a result counter.
// Latency: a result pushed in cycle N is visible on out_valid in cycle N+1; there is no bypass when the buffer is empty.
// Backpressure: in_ready drops only when all DEPTH entries are occupied; out_ready stalls the head entry, which then stays stable.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          producer handshake for f_prod, u_flow, o_flow
//   out_valid/out_ready        consumer handshake for out_data and out_flags ({o_flow, u_flow})
//   sticky_uflow/sticky_oflow  set by any accepted result that carried the flag
//   op_count                   saturating count of accepted results
//   stat_clr                   synchronous clear of the sticky flags and op_count
module fpmul_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   f_prod,
  input  logic          u_flow,
  input  logic          o_flow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [1:0]    out_flags,
  output logic          sticky_uflow,
  output logic          sticky_oflow,
  output logic [CW-1:0] op_count,
  input  logic          stat_clr
);

  // A stored entry. The field order matches the {o_flow, u_flow, f_prod} word layout.
  typedef struct packed {
    logic        o_flow;
    logic        u_flow;
    logic [31:0] prod;
  } entry_t;

  localparam logic [AW:0]   OCC_FULL  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic            sticky_u_q, sticky_u_d;
  logic            sticky_o_q, sticky_o_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push;
  logic            pop;
  entry_t          in_entry;
  entry_t          head;

  // Both handshake outputs depend only on registered occupancy. This keeps
  // them free of combinational paths from in_valid or out_ready.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign in_entry = '{o_flow: o_flow, u_flow: u_flow, prod: f_prod};
  assign head     = mem_q[rd_ptr_q];

  assign out_data     = head.prod;
  assign out_flags    = {head.o_flow, head.u_flow};
  assign sticky_uflow = sticky_u_q;
  assign sticky_oflow = sticky_o_q;
  assign op_count     = count_q;

  // Storage, pointers and occupancy.
  // DEPTH is 2**AW, so the pointers wrap by natural AW-bit overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Status. The clear is applied first and the push second. When both happen
  // in one cycle, the stats show only the new result.
  always_comb begin
    sticky_u_d = stat_clr ? 1'b0 : sticky_u_q;
    sticky_o_d = stat_clr ? 1'b0 : sticky_o_q;
    count_d    = stat_clr ? '0   : count_q;

    if (push) begin
      sticky_u_d = sticky_u_d | u_flow;
      sticky_o_d = sticky_o_d | o_flow;
      if (count_d != COUNT_MAX) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      sticky_u_q <= 1'b0;
      sticky_o_q <= 1'b0;
      count_q    <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      sticky_u_q <= sticky_u_d;
      sticky_o_q <= sticky_o_d;
      count_q    <= count_d;
    end
  end

endmodule
